pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
// Central stall/flush sequencer for the 5-stage RV pipeline (F/D/E/M/W). Consumes decode-stage
// control (pause, source regs) and execute-stage control (memtoreg, writesreg, jump, rd).
// Generates per-stage stall/flush strobes for the pipeline registers: load-use interlock,
// jump flush, and the PAUSE (FENCE-class) drain-and-hold sequence.
// PARAMETERS
// HOLD_CYCLES  4  cycles held idle after drain completes, before PAUSE retires (>=1)
// REG_W        5  register index width
// PORTS
// clk            in   1      rising-edge clock
// reset          in   1      synchronous, active-high
// d_valid        in   1      D stage holds a real instruction
// d_pause        in   1      D instruction is PAUSE (maindec pause)
// d_rs1, d_rs2   in   REG_W  D source registers
// d_use_rs1/2    in   1      D instruction reads rs1 / rs2
// e_memtoreg     in   1      E instruction is a load
// e_writesreg    in   1      E instruction writes rd
// e_rd           in   REG_W  E destination register
// e_jump         in   1      E resolved a taken jump (redirect this cycle)
// stall_f        out  1      hold PC / F-D register
// stall_d        out  1      hold D register contents
// flush_d        out  1      clear F-D register (bubble into D next cycle)
// flush_e        out  1      clear D-E register (bubble into E next cycle)
// pause_busy     out  1      PAUSE sequence in progress (state != RUN)
// BEHAVIOUR
// - Reset: all outputs 0; state RUN; valid tracker v_e=v_m=v_w=0; hold counter 0.
// - Valid tracker: v_e <= d_valid & ~flush_e & ~stall_d; v_m <= v_e; v_w <= v_m. Reset clears.
// - load_use = e_memtoreg & e_writesreg & (e_rd!=0) & d_valid &
//   ((d_use_rs1 & d_rs1==e_rd) | (d_use_rs2 & d_rs2==e_rd)). Combinational.
// - FSM RUN: jump -> flush_d=flush_e=1, stalls 0 (jump has top priority, overrides load_use
//   and pause). Else load_use -> stall_f=stall_d=flush_e=1 for exactly one cycle.
//   Else d_valid & d_pause -> stall_f=stall_d=flush_e=1, go DRAIN.
// - DRAIN: stall_f=stall_d=flush_e=1. When v_e|v_m|v_w == 0 -> HOLD, counter=HOLD_CYCLES-1.
//   e_jump during DRAIN (older instruction redirects): flush_d=flush_e=1, stalls 0, back to RUN
//   (PAUSE discarded, never retires).
// - HOLD: stall_f=stall_d=flush_e=1; counter decrements; at 0 -> RESUME.
// - RESUME: stall_f=stall_d=0, flush_d=0, flush_e=1 (PAUSE retires as bubble; next F
//   instruction enters D); -> RUN next cycle. One cycle only.
// - pause_busy = (state != RUN); combinational from state.
// - Stall/flush outputs are combinational from state + inputs; zero added latency.
// - Drain latency: PAUSE in D with E/M/W all valid -> 3 DRAIN cycles, HOLD_CYCLES, 1 RESUME.
// - Back-to-back PAUSE: second PAUSE arrives in D the cycle after RESUME -> new DRAIN (pipe
//   already empty, so exactly 1 DRAIN cycle).
// - Reset mid-DRAIN/HOLD: returns to RUN next edge, all strobes 0, tracker cleared.
// - x0 never causes an interlock. d_valid=0 never causes stall or PAUSE entry.
// STRUCTURE
// - Shared package/header (inst.v): state encoding localparams ST_RUN/ST_DRAIN/ST_HOLD/
//   ST_RESUME (2-bit), PAUSE_OP reused for bench decode.
// - One sub-module: hazard_detect (combinational load_use compare); FSM, counter, tracker inline.
// TESTING
// 1 Reset: assert reset 2 cycles mid-HOLD -> all outputs 0, pause_busy 0 next cycle.
// 2 Load-use: E lw x5, D add x6,x5,x1 -> stall_f=stall_d=flush_e=1 one cycle, then 0;
//   same with e_rd=0 -> no stall.
// 3 PAUSE, full pipe, HOLD_CYCLES=4: pause_busy high 3+4+1=8 cycles; flush_e=1 all 8;
//   stall_f released on RESUME cycle only.
// 4 Jump during DRAIN: e_jump at DRAIN cycle 1 -> flush_d=flush_e=1, state RUN next cycle,
//   no HOLD entered.
// 5 Jump + load_use + pause same cycle in RUN -> only flush_d/flush_e, stalls 0.
// 6 Back-to-back PAUSE after RESUME -> exactly 1 DRAIN cycle then HOLD.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard sequencer: FSM state encoding and
// the PAUSE opcode used when decoding instruction words.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HOLD   = 2'd2,
        ST_RESUME = 2'd3
    } state_e;

    // FENCE-class major opcode; PAUSE is encoded within it.
    localparam logic [6:0] PAUSE_OP = 7'b0001111;

    function automatic logic is_pause_op(input logic [6:0] opcode);
        return opcode == PAUSE_OP;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use interlock compare: a load in E whose rd is read by the valid D instruction.
module hazard_detect #(
    parameter int unsigned REG_W = 5
) (
    input  logic             d_valid_i,
    input  logic [REG_W-1:0] d_rs1_i,
    input  logic [REG_W-1:0] d_rs2_i,
    input  logic             d_use_rs1_i,
    input  logic             d_use_rs2_i,
    input  logic             e_memtoreg_i,
    input  logic             e_writesreg_i,
    input  logic [REG_W-1:0] e_rd_i,
    output logic             load_use_o
);

    logic rs1_hit;
    logic rs2_hit;

    always_comb begin
        rs1_hit    = d_use_rs1_i && (d_rs1_i == e_rd_i);
        rs2_hit    = d_use_rs2_i && (d_rs2_i == e_rd_i);
        // x0 is hardwired zero, so a load targeting it never creates a dependency.
        load_use_o = e_memtoreg_i && e_writesreg_i && (e_rd_i != '0) &&
                     d_valid_i && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use interlock, jump flush,
// and the PAUSE drain-and-hold sequence.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned REG_W       = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d_valid,
    input  logic             d_pause,
    input  logic [REG_W-1:0] d_rs1,
    input  logic [REG_W-1:0] d_rs2,
    input  logic             d_use_rs1,
    input  logic             d_use_rs2,
    input  logic             e_memtoreg,
    input  logic             e_writesreg,
    input  logic [REG_W-1:0] e_rd,
    input  logic             e_jump,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_d,
    output logic             flush_e,
    output logic             pause_busy
);

    localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             v_e_q, v_m_q, v_w_q;
    logic             load_use;
    logic             sf, sd, fd, fe;

    hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
        .d_valid_i     (d_valid),
        .d_rs1_i       (d_rs1),
        .d_rs2_i       (d_rs2),
        .d_use_rs1_i   (d_use_rs1),
        .d_use_rs2_i   (d_use_rs2),
        .e_memtoreg_i  (e_memtoreg),
        .e_writesreg_i (e_writesreg),
        .e_rd_i        (e_rd),
        .load_use_o    (load_use)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sf      = 1'b0;
        sd      = 1'b0;
        fd      = 1'b0;
        fe      = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (e_jump) begin
                    fd = 1'b1;
                    fe = 1'b1;
                end else if (load_use) begin
                    sf = 1'b1;
                    sd = 1'b1;
                    fe = 1'b1;
                end else if (d_valid && d_pause) begin
                    sf      = 1'b1;
                    sd      = 1'b1;
                    fe      = 1'b1;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // An older instruction redirecting squashes the PAUSE itself.
                if (e_jump) begin
                    fd      = 1'b1;
                    fe      = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    sf = 1'b1;
                    sd = 1'b1;
                    fe = 1'b1;
                    if (!(v_e_q || v_m_q || v_w_q)) begin
                        state_d = ST_HOLD;
                        cnt_d   = CNT_W'(HOLD_CYCLES - 1);
                    end
                end
            end
            ST_HOLD: begin
                sf = 1'b1;
                sd = 1'b1;
                fe = 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_RESUME;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESUME: begin
                fe      = 1'b1;
                state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        stall_f    = sf && !reset;
        stall_d    = sd && !reset;
        flush_d    = fd && !reset;
        flush_e    = fe && !reset;
        pause_busy = (state_q != ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            v_e_q   <= 1'b0;
            v_m_q   <= 1'b0;
            v_w_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            v_e_q   <= d_valid && !fe && !sd;
            v_m_q   <= v_e_q;
            v_w_q   <= v_m_q;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: per-cycle stimulus rows with expected
// strobe vectors {stall_f, stall_d, flush_d, flush_e, pause_busy}.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       d_valid, d_pause, d_use_rs1, d_use_rs2;
    logic [4:0] d_rs1, d_rs2, e_rd;
    logic       e_memtoreg, e_writesreg, e_jump;
    logic       stall_f, stall_d, flush_d, flush_e, pause_busy;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       rst, valid, pause, jump, u1, u2, mem, wr;
        logic [4:0] rs1, rs2, rd;
    } stim_t;

    localparam logic [4:0] E_NONE = 5'b00000;
    localparam logic [4:0] E_LU   = 5'b11010;
    localparam logic [4:0] E_BUSY = 5'b11011;
    localparam logic [4:0] E_RES  = 5'b00011;
    localparam logic [4:0] E_JMP  = 5'b00110;
    localparam logic [4:0] E_JMPB = 5'b00111;
    localparam logic [4:0] E_RSTB = 5'b00001;

    logic [4:0] exp_q[$];

    pipe_hazard_ctrl #(.HOLD_CYCLES(4), .REG_W(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .d_valid     (d_valid),
        .d_pause     (d_pause),
        .d_rs1       (d_rs1),
        .d_rs2       (d_rs2),
        .d_use_rs1   (d_use_rs1),
        .d_use_rs2   (d_use_rs2),
        .e_memtoreg  (e_memtoreg),
        .e_writesreg (e_writesreg),
        .e_rd        (e_rd),
        .e_jump      (e_jump),
        .stall_f     (stall_f),
        .stall_d     (stall_d),
        .flush_d     (flush_d),
        .flush_e     (flush_e),
        .pause_busy  (pause_busy)
    );

    always #5 clk = ~clk;

    function automatic stim_t mk(input logic rst, valid, pause, jump, u1, u2, mem, wr,
                                 input logic [4:0] rs1, rs2, rd);
        stim_t s;
        s.rst = rst; s.valid = valid; s.pause = pause; s.jump = jump;
        s.u1 = u1; s.u2 = u2; s.mem = mem; s.wr = wr;
        s.rs1 = rs1; s.rs2 = rs2; s.rd = rd;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        reset = s.rst; d_valid = s.valid; d_pause = s.pause; e_jump = s.jump;
        d_use_rs1 = s.u1; d_use_rs2 = s.u2; e_memtoreg = s.mem; e_writesreg = s.wr;
        d_rs1 = s.rs1; d_rs2 = s.rs2; e_rd = s.rd;
    endtask

    stim_t IDLE, VAL, PAUSE;

    task automatic test_reset();
        stim_t s[$]; logic [4:0] x[$]; logic [4:0] got, e;
        s.push_back(mk(1,0,0,0,0,0,0,0,0,0,0)); x.push_back(E_NONE);
        s.push_back(mk(1,1,1,0,0,0,0,0,0,0,0)); x.push_back(E_NONE);
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]); exp_q.push_back(x[i]);
            @(negedge clk);
            got = {stall_f, stall_d, flush_d, flush_e, pause_busy}; e = exp_q.pop_front();
            checks++;
            if (got !== e) begin errors++; $display("FAIL reset[%0d]: got %b expected %b", i, got, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        stim_t s[$]; logic [4:0] x[$]; logic [4:0] got, e;
        s.push_back(mk(0,1,0,0,1,1,1,1,5,1,5)); x.push_back(E_LU);   // lw x5 / add x6,x5,x1
        s.push_back(mk(0,1,0,0,1,1,0,0,5,1,0)); x.push_back(E_NONE); // bubble now in E
        s.push_back(mk(0,1,0,0,1,1,1,1,1,5,5)); x.push_back(E_LU);   // rs2 match
        s.push_back(mk(0,1,0,0,1,1,1,1,0,0,0)); x.push_back(E_NONE); // rd = x0
        s.push_back(mk(0,1,0,0,1,1,1,0,5,1,5)); x.push_back(E_NONE); // no writeback
        s.push_back(mk(0,1,0,0,0,1,1,1,5,1,5)); x.push_back(E_NONE); // rs1 not read
        s.push_back(mk(0,0,0,0,1,1,1,1,5,1,5)); x.push_back(E_NONE); // D invalid
        s.push_back(mk(0,1,0,0,1,1,0,1,5,1,5)); x.push_back(E_NONE); // not a load
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]); exp_q.push_back(x[i]);
            @(negedge clk);
            got = {stall_f, stall_d, flush_d, flush_e, pause_busy}; e = exp_q.pop_front();
            checks++;
            if (got !== e) begin errors++; $display("FAIL load_use[%0d]: got %b expected %b", i, got, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_pause_full();
        stim_t s[$]; logic [4:0] x[$]; logic [4:0] got, e;
        for (int k = 0; k < 3; k++) begin s.push_back(VAL); x.push_back(E_NONE); end
        s.push_back(PAUSE); x.push_back(E_LU);
        for (int k = 0; k < 7; k++) begin s.push_back(PAUSE); x.push_back(E_BUSY); end
        s.push_back(PAUSE); x.push_back(E_RES);
        s.push_back(VAL);   x.push_back(E_NONE);
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]); exp_q.push_back(x[i]);
            @(negedge clk);
            got = {stall_f, stall_d, flush_d, flush_e, pause_busy}; e = exp_q.pop_front();
            checks++;
            if (got !== e) begin errors++; $display("FAIL pause_full[%0d]: got %b expected %b", i, got, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_jump_drain();
        stim_t s[$]; logic [4:0] x[$]; logic [4:0] got, e;
        for (int k = 0; k < 3; k++) begin s.push_back(VAL); x.push_back(E_NONE); end
        s.push_back(PAUSE); x.push_back(E_LU);
        s.push_back(mk(0,1,1,1,0,0,0,0,0,0,0)); x.push_back(E_JMPB);
        s.push_back(IDLE); x.push_back(E_NONE);
        s.push_back(IDLE); x.push_back(E_NONE);
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]); exp_q.push_back(x[i]);
            @(negedge clk);
            got = {stall_f, stall_d, flush_d, flush_e, pause_busy}; e = exp_q.pop_front();
            checks++;
            if (got !== e) begin errors++; $display("FAIL jump_drain[%0d]: got %b expected %b", i, got, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_jump_priority();
        stim_t s[$]; logic [4:0] x[$]; logic [4:0] got, e;
        s.push_back(mk(0,1,1,1,1,0,1,1,5,0,5)); x.push_back(E_JMP);
        s.push_back(IDLE); x.push_back(E_NONE);
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]); exp_q.push_back(x[i]);
            @(negedge clk);
            got = {stall_f, stall_d, flush_d, flush_e, pause_busy}; e = exp_q.pop_front();
            checks++;
            if (got !== e) begin errors++; $display("FAIL jump_priority[%0d]: got %b expected %b", i, got, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        stim_t s[$]; logic [4:0] x[$]; logic [4:0] got, e;
        for (int k = 0; k < 3; k++) begin s.push_back(VAL); x.push_back(E_NONE); end
        s.push_back(PAUSE); x.push_back(E_LU);
        for (int k = 0; k < 7; k++) begin s.push_back(PAUSE); x.push_back(E_BUSY); end
        s.push_back(PAUSE); x.push_back(E_RES);
        // second PAUSE: pipe already empty, so 1 DRAIN + 4 HOLD
        s.push_back(PAUSE); x.push_back(E_LU);
        for (int k = 0; k < 5; k++) begin s.push_back(PAUSE); x.push_back(E_BUSY); end
        s.push_back(PAUSE); x.push_back(E_RES);
        s.push_back(IDLE);  x.push_back(E_NONE);
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]); exp_q.push_back(x[i]);
            @(negedge clk);
            got = {stall_f, stall_d, flush_d, flush_e, pause_busy}; e = exp_q.pop_front();
            checks++;
            if (got !== e) begin errors++; $display("FAIL back_to_back[%0d]: got %b expected %b", i, got, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_hold();
        stim_t s[$]; logic [4:0] x[$]; logic [4:0] got, e;
        for (int k = 0; k < 3; k++) begin s.push_back(VAL); x.push_back(E_NONE); end
        s.push_back(PAUSE); x.push_back(E_LU);
        for (int k = 0; k < 5; k++) begin s.push_back(PAUSE); x.push_back(E_BUSY); end
        s.push_back(mk(1,1,1,0,0,0,0,0,0,0,0)); x.push_back(E_RSTB);
        s.push_back(mk(1,1,1,0,0,0,0,0,0,0,0)); x.push_back(E_NONE);
        s.push_back(PAUSE); x.push_back(E_LU);
        for (int k = 0; k < 5; k++) begin s.push_back(PAUSE); x.push_back(E_BUSY); end
        s.push_back(PAUSE); x.push_back(E_RES);
        s.push_back(IDLE);  x.push_back(E_NONE);
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]); exp_q.push_back(x[i]);
            @(negedge clk);
            got = {stall_f, stall_d, flush_d, flush_e, pause_busy}; e = exp_q.pop_front();
            checks++;
            if (got !== e) begin errors++; $display("FAIL reset_mid_hold[%0d]: got %b expected %b", i, got, e); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        IDLE  = mk(0,0,0,0,0,0,0,0,0,0,0);
        VAL   = mk(0,1,0,0,0,0,0,0,0,0,0);
        PAUSE = mk(0,1,1,0,0,0,0,0,0,0,0);
        apply(mk(1,0,0,0,0,0,0,0,0,0,0));
        @(posedge clk); #1;
        test_reset();
        test_load_use();
        test_pause_full();
        test_jump_drain();
        test_jump_priority();
        test_back_to_back();
        test_reset_mid_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
